muldiv_issue_controller: RTL

//  Sequences the multi-cycle mul/div unit in the execute stage. Detects a mul/div op entering EX,

---
 rtl/muldiv_issue_controller_if.sv | 29 ++
 rtl/muldiv_issue_controller.sv | 109 ++++++++++
 2 files changed

// File: rtl/muldiv_issue_controller_if.sv
// Pipeline <-> mul/div issue controller signal bundle.
//   master : EX-stage/pipeline side; drives the op description, flush and external stall.
//   slave  : issue controller; returns the structure stall, unit control pulses and status.
// Signals:
//   isMulDiv, mulDivCode[2:0], op2IsZero, isBranchPredictMiss, extStall  (master -> slave)
//   mulDivStall, unitStart, unitKill, resultValid, busy, curCode[2:0]    (slave -> master)
interface muldiv_issue_controller_if;
  logic       isMulDiv;
  logic [2:0] mulDivCode;
  logic       op2IsZero;
  logic       isBranchPredictMiss;
  logic       extStall;
  logic       mulDivStall;
  logic       unitStart;
  logic       unitKill;
  logic       resultValid;
  logic       busy;
  logic [2:0] curCode;

  modport master (
    output isMulDiv, mulDivCode, op2IsZero, isBranchPredictMiss, extStall,
    input  mulDivStall, unitStart, unitKill, resultValid, busy, curCode
  );

  modport slave (
    input  isMulDiv, mulDivCode, op2IsZero, isBranchPredictMiss, extStall,
    output mulDivStall, unitStart, unitKill, resultValid, busy, curCode
  );
endinterface

// File: rtl/muldiv_issue_controller.sv
// Mul/div issue controller for the execute stage.
// Detects a mul/div op in EX, pulses unitStart, holds the front of the pipe with a
// structure stall for the op's latency, then presents resultValid until the op moves
// to EX/MEM. A branch mispredict kills an in-flight op.
// Ports:
//   clk  : pipeline clock; state advances on the falling edge, like the stage registers
//   rst  : asynchronous, active-low reset
//   bus  : muldiv_issue_controller_if.slave (op inputs, stall/control/status outputs)
module muldiv_issue_controller #(
  parameter int MUL_LATENCY   = 3,
  parameter int DIV_LATENCY   = 34,
  parameter int DIV_ZERO_FAST = 1,
  parameter int CNT_W         = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  muldiv_issue_controller_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        cur_code, cur_code_nxt;
  logic [CNT_W-1:0]  lat;
  logic              issue;
  logic              unit_start, stall, kill, res_valid;

  // Stall length of the op currently presented in EX.
  always_comb begin
    if (bus.mulDivCode[2]) begin
      if ((DIV_ZERO_FAST != 0) && bus.op2IsZero) lat = CNT_W'(1);
      else                                       lat = CNT_W'(DIV_LATENCY);
    end else begin
      lat = CNT_W'(MUL_LATENCY);
    end
  end

  // rst gates issue so every output reads 0 while reset is held, even with isMulDiv high.
  assign issue = rst && (state == IDLE) && bus.isMulDiv && !bus.isBranchPredictMiss;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_code_nxt = cur_code;
    unit_start   = 1'b0;
    stall        = 1'b0;
    kill         = 1'b0;
    res_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          unit_start   = 1'b1;
          stall        = 1'b1;
          cnt_nxt      = lat - CNT_W'(1);
          cur_code_nxt = bus.mulDivCode;
          state_nxt    = (lat == CNT_W'(1)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.isBranchPredictMiss) begin
          kill      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          // extStall does not pause the count: the unit runs independently of the pipe.
          stall   = 1'b1;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.isBranchPredictMiss) begin
          kill      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          // isMulDiv is still high here for the same op; only leaving DONE frees the slot.
          res_valid = 1'b1;
          if (!bus.extStall) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_code <= 3'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_code <= cur_code_nxt;
    end
  end

  assign bus.unitStart   = unit_start;
  assign bus.mulDivStall = stall;
  assign bus.unitKill    = kill;
  assign bus.resultValid = res_valid;
  assign bus.busy        = (state != IDLE);
  assign bus.curCode     = cur_code;

endmodule
